// File: rtl/relu_array_pipe.sv
// relu_array_pipe
//   Two-stage pipelined activation array for the RELU_BOUND datapath.
//   Each of COLS lanes takes a signed BO_BW-bit bound-stage result, applies a
//   round-half-up arithmetic right shift, one of four activation modes and
//   saturation to ACT_BW bits. Full valid/ready backpressure, 1 beat/cycle.
//
// Ports
//   i_clk, i_rst     clock (rising edge), asynchronous active-high reset
//   i_valid/o_ready  input beat handshake (o_ready is combinational)
//   i_bound_data     COLS lanes of BO_BW-bit two's complement
//   i_mode           0=ReLU, 1=clipped ReLU, 2=leaky (1/8), 3=signed pass
//   i_shift          requantisation shift amount
//   i_clip_max       unsigned ceiling for mode 1
//   o_valid/i_ready  output beat handshake
//   o_act_data       COLS lanes of ACT_BW-bit results
//   o_sat_flag       per-lane flag: ACT_BW range saturation altered the lane
//
// Build option
//   RELU_SAT_CNT_EN  adds i_sat_clr / o_sat_cnt: a 16-bit saturating count of
//                    flagged lanes over all output handshakes.

module relu_array_pipe #(
    parameter int COLS     = 5,
    parameter int BO_BW    = 16,
    parameter int ACT_BW   = 8,
    parameter int SHIFT_BW = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [BO_BW*COLS-1:0]    i_bound_data,
    input  logic [1:0]               i_mode,
    input  logic [SHIFT_BW-1:0]      i_shift,
    input  logic [ACT_BW-1:0]        i_clip_max,
`ifdef RELU_SAT_CNT_EN
    input  logic                     i_sat_clr,
    output logic [15:0]              o_sat_cnt,
`endif
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [ACT_BW*COLS-1:0]   o_act_data,
    output logic [COLS-1:0]          o_sat_flag
);

    // Arithmetic width: one guard bit so the rounding add cannot overflow.
    localparam int RW = BO_BW + 1;
    localparam logic signed [RW-1:0] U_MAX = RW'((2 ** ACT_BW) - 1);
    localparam logic signed [RW-1:0] S_MAX = RW'((2 ** (ACT_BW - 1)) - 1);
    localparam logic signed [RW-1:0] S_MIN = RW'(-(2 ** (ACT_BW - 1)));

    logic                  en1;
    logic                  en2;

    logic                  s1_valid;
    logic [BO_BW*COLS-1:0] s1_data;
    logic [1:0]            s1_mode;
    logic [SHIFT_BW-1:0]   s1_shift;
    logic [ACT_BW-1:0]     s1_clip;

    logic [ACT_BW*COLS-1:0] act_next;
    logic [COLS-1:0]        sat_next;

    // ---------------------------------------------------------------
    // Handshake: a stage may load when it is empty or draining.
    // ---------------------------------------------------------------
    assign en2     = !o_valid || i_ready;
    assign en1     = !s1_valid || en2;
    assign o_ready = en1;

    // ---------------------------------------------------------------
    // S1: capture the beat and its per-beat configuration.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
            s1_shift <= '0;
            s1_clip  <= '0;
        end else if (en1) begin
            s1_valid <= i_valid && o_ready;
            s1_data  <= i_bound_data;
            s1_mode  <= i_mode;
            s1_shift <= i_shift;
            s1_clip  <= i_clip_max;
        end
    end

    // ---------------------------------------------------------------
    // Per-lane requantisation and activation on S1 contents.
    // ---------------------------------------------------------------
    logic signed [RW-1:0]  x_ext;
    logic signed [RW-1:0]  half;
    logic signed [RW-1:0]  r;
    logic signed [RW-1:0]  sv;
    logic signed [RW-1:0]  clip_ext;
    logic [ACT_BW-1:0]     res;
    logic                  flag;
    int unsigned           sh_amt;

    always_comb begin
        act_next = '0;
        sat_next = '0;
        x_ext    = '0;
        half     = '0;
        r        = '0;
        sv       = '0;
        res      = '0;
        flag     = 1'b0;
        clip_ext = {{(RW - ACT_BW){1'b0}}, s1_clip};

        // Shifts at or beyond the input width collapse to BO_BW-1.
        sh_amt = 32'(s1_shift);
        if (sh_amt > unsigned'(BO_BW - 1))
            sh_amt = unsigned'(BO_BW - 1);

        for (int unsigned i = 0; i < COLS; i++) begin
            x_ext = {s1_data[i*BO_BW + BO_BW - 1], s1_data[i*BO_BW +: BO_BW]};

            if (sh_amt == 0) begin
                r = x_ext;
            end else begin
                half = RW'(1) << (sh_amt - 1);
                r    = (x_ext + half) >>> sh_amt;
            end

            // Signed-saturation source: leaky slope floors negatives by 1/8.
            sv   = (s1_mode == 2'd2 && r[RW-1]) ? (r >>> 3) : r;
            res  = r[ACT_BW-1:0];
            flag = 1'b0;

            case (s1_mode)
                2'd0: begin
                    if (r[RW-1]) begin
                        res = '0;
                    end else if (r > U_MAX) begin
                        res  = '1;
                        flag = 1'b1;
                    end
                end
                2'd1: begin
                    // Clipping to the ceiling is not range saturation.
                    if (r[RW-1])
                        res = '0;
                    else if (r > clip_ext)
                        res = s1_clip;
                end
                default: begin
                    res = sv[ACT_BW-1:0];
                    if (sv > S_MAX) begin
                        res  = {1'b0, {(ACT_BW - 1){1'b1}}};
                        flag = 1'b1;
                    end else if (sv < S_MIN) begin
                        res  = {1'b1, {(ACT_BW - 1){1'b0}}};
                        flag = 1'b1;
                    end
                end
            endcase

            act_next[i*ACT_BW +: ACT_BW] = res;
            sat_next[i]                  = flag;
        end
    end

    // ---------------------------------------------------------------
    // S2: output register, holds while stalled.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_act_data <= '0;
            o_sat_flag <= '0;
        end else if (en2) begin
            o_valid    <= s1_valid;
            o_act_data <= act_next;
            o_sat_flag <= sat_next;
        end
    end

`ifdef RELU_SAT_CNT_EN
    // ---------------------------------------------------------------
    // Saturation event counter, sticks at all-ones.
    // ---------------------------------------------------------------
    localparam int PW = $clog2(COLS + 1);

    logic [PW-1:0] sat_pop;
    logic [16:0]   cnt_sum;

    always_comb begin
        sat_pop = '0;
        for (int unsigned i = 0; i < COLS; i++)
            sat_pop = sat_pop + PW'(o_sat_flag[i]);
        cnt_sum = {1'b0, o_sat_cnt} + 17'(sat_pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sat_cnt <= '0;
        end else if (i_sat_clr) begin
            o_sat_cnt <= '0;
        end else if (o_valid && i_ready) begin
            o_sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_relu_array_pipe.sv
// tb_relu_array_pipe
//   Directed self-checking bench for relu_array_pipe with default parameters
//   (5 lanes, 16-bit in, 8-bit out). Counter checks are compiled only when
//   RELU_SAT_CNT_EN is defined.

module tb_relu_array_pipe;

    localparam int COLS   = 5;
    localparam int BO_BW  = 16;
    localparam int ACT_BW = 8;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_valid;
    logic                   o_ready;
    logic [BO_BW*COLS-1:0]  i_bound_data;
    logic [1:0]             i_mode;
    logic [3:0]             i_shift;
    logic [ACT_BW-1:0]      i_clip_max;
    logic                   o_valid;
    logic                   i_ready;
    logic [ACT_BW*COLS-1:0] o_act_data;
    logic [COLS-1:0]        o_sat_flag;
`ifdef RELU_SAT_CNT_EN
    logic                   i_sat_clr;
    logic [15:0]            o_sat_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    relu_array_pipe #(
        .COLS     (COLS),
        .BO_BW    (BO_BW),
        .ACT_BW   (ACT_BW),
        .SHIFT_BW (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_bound_data (i_bound_data),
        .i_mode       (i_mode),
        .i_shift      (i_shift),
        .i_clip_max   (i_clip_max),
`ifdef RELU_SAT_CNT_EN
        .i_sat_clr    (i_sat_clr),
        .o_sat_cnt    (o_sat_cnt),
`endif
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_act_data   (o_act_data),
        .o_sat_flag   (o_sat_flag)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One isolated beat: latency, result, flags and drain.
    task automatic run_beat(input string tag, input logic [79:0] d, input logic [1:0] m,
                            input logic [3:0] sh, input logic [7:0] clip,
                            input logic [39:0] ea, input logic [4:0] ef);
        i_bound_data = d;
        i_mode       = m;
        i_shift      = sh;
        i_clip_max   = clip;
        i_ready      = 1'b1;
        i_valid      = 1'b1;
        #1;
        check({tag, "_rdy"}, 80'(o_ready), 80'd1);
        @(posedge i_clk);
        #1;
        // Scramble inputs after acceptance; the beat must keep its own config.
        i_valid      = 1'b0;
        i_bound_data = '1;
        i_mode       = ~m;
        i_shift      = ~sh;
        i_clip_max   = ~clip;
        check({tag, "_lat1"}, 80'(o_valid), 80'd0);
        tick();
        check({tag, "_vld"}, 80'(o_valid), 80'd1);
        check({tag, "_dat"}, 80'(o_act_data), 80'(ea));
        check({tag, "_flg"}, 80'(o_sat_flag), 80'(ef));
        tick();
        check({tag, "_drn"}, 80'(o_valid), 80'd0);
    endtask

    // Streaming vectors: lane i of beat k carries 16*k+i+1, passed unchanged in mode 3.
    function automatic logic [79:0] beat_in(input int k);
        logic [79:0] v;
        v = '0;
        for (int i = 0; i < COLS; i++)
            v[i*BO_BW +: BO_BW] = 16'(16 * k + i + 1);
        return v;
    endfunction

    function automatic logic [39:0] beat_exp(input int k);
        logic [39:0] v;
        v = '0;
        for (int i = 0; i < COLS; i++)
            v[i*ACT_BW +: ACT_BW] = 8'(16 * k + i + 1);
        return v;
    endfunction

    initial begin
        int  sent;
        int  rcv;
        int  inflight;
        bit  saw_block;
        bit  acc;
        bit  hs;

        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_ready      = 1'b1;
        i_bound_data = '0;
        i_mode       = 2'd0;
        i_shift      = 4'd0;
        i_clip_max   = 8'd0;
`ifdef RELU_SAT_CNT_EN
        i_sat_clr    = 1'b0;
`endif
        #1;
        check("rst_vld", 80'(o_valid), 80'd0);
        check("rst_dat", 80'(o_act_data), 80'd0);
        check("rst_flg", 80'(o_sat_flag), 80'd0);
        check("rst_rdy", 80'(o_ready), 80'd1);
        repeat (2) tick();
        i_rst = 1'b0;
        check("post_rst_rdy", 80'(o_ready), 80'd1);

        // Mode 0: {-5,0,100,300,-32768} -> {0,0,100,255,0}
        run_beat("t1", 80'h8000_012C_0064_0000_FFFB, 2'd0, 4'd0, 8'd0,
                 40'h00_FF_64_00_00, 5'b01000);
        // Mode 1, clip 6, shift 2: {25,23,-4,2,1000} -> {6,6,0,1,6}
        run_beat("t2", 80'h03E8_0002_FFFC_0017_0019, 2'd1, 4'd2, 8'd6,
                 40'h06_01_00_06_06, 5'b00000);
        // Mode 2: {-80,-7,50,200,-2000} -> {F6,FF,32,7F,80}
        run_beat("t3", 80'hF830_00C8_0032_FFF9_FFB0, 2'd2, 4'd0, 8'd0,
                 40'h80_7F_32_FF_F6, 5'b11000);
        // Mode 0, shift 2: {-2,-6,1022,1021,6} -> {0,0,255(sat),255,2}
        run_beat("t0r", 80'h0006_03FD_03FE_FFFA_FFFE, 2'd0, 4'd2, 8'd0,
                 40'h02_FF_FF_00_00, 5'b00100);
        // Mode 1, clip 200: {1000,-1000,300,254,0} -> {200,0,200,200,0}
        run_beat("t1c", 80'h0000_00FE_012C_FC18_03E8, 2'd1, 4'd0, 8'd200,
                 40'h00_C8_C8_00_C8, 5'b00000);
        // Mode 3, shift 1: {255,256,-257,-258,3} -> {127s,127s,-128,-128s,2}
        run_beat("t3s", 80'h0003_FEFE_FEFF_0100_00FF, 2'd3, 4'd1, 8'd0,
                 40'h02_80_80_7F_7F, 5'b01011);
        // Mode 3, shift 15: {-32768,16384,16383,32767,-16384} -> {-1,1,0,1,0}
        run_beat("t3m", 80'hC000_7FFF_3FFF_4000_8000, 2'd3, 4'd15, 8'd0,
                 40'h00_01_00_01_FF, 5'b00000);

        // Streaming with a 3-cycle downstream stall.
        sent      = 0;
        rcv       = 0;
        inflight  = 0;
        saw_block = 1'b0;
        i_mode    = 2'd3;
        i_shift   = 4'd0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            i_valid      = (sent < 6);
            i_bound_data = beat_in(sent);
            i_ready      = !(cyc >= 2 && cyc <= 4);
            #1;
            check("t4_rdy", 80'(o_ready), (inflight == 2 && !i_ready) ? 80'd0 : 80'd1);
            if (!o_ready) saw_block = 1'b1;
            if (inflight == 0) check("t4_empty", 80'(o_valid), 80'd0);
            if (o_valid) check("t4_dat", 80'(o_act_data), 80'(beat_exp(rcv)));
            acc = i_valid && o_ready;
            hs  = o_valid && i_ready;
            tick();
            if (acc) sent++;
            if (hs)  rcv++;
            inflight = inflight + int'(acc) - int'(hs);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("t4_sent", 80'(sent), 80'd6);
        check("t4_rcv", 80'(rcv), 80'd6);
        check("t4_block", 80'(saw_block), 80'd1);

        // Reset with both stages full and output stalled.
        i_mode       = 2'd0;
        i_shift      = 4'd0;
        i_bound_data = 80'h8000_012C_0064_0000_FFFB;
        i_valid      = 1'b1;
        i_ready      = 1'b0;
        tick();
        tick();
        check("t5_pre_vld", 80'(o_valid), 80'd1);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        #1;
        check("t5_vld", 80'(o_valid), 80'd0);
        check("t5_dat", 80'(o_act_data), 80'd0);
        check("t5_flg", 80'(o_sat_flag), 80'd0);
        check("t5_rdy", 80'(o_ready), 80'd1);
        @(posedge i_clk);
        #1;
        i_rst        = 1'b0;
        i_ready      = 1'b1;
        i_mode       = 2'd2;
        i_bound_data = 80'hF830_00C8_0032_FFF9_FFB0;
        i_valid      = 1'b1;
        tick();
        i_valid = 1'b0;
        check("t5_lat1", 80'(o_valid), 80'd0);
        tick();
        check("t5_new_vld", 80'(o_valid), 80'd1);
        check("t5_new_dat", 80'(o_act_data), 80'h80_7F_32_FF_F6);
        check("t5_new_flg", 80'(o_sat_flag), 80'(5'b11000));
        tick();
        check("t5_no_stale", 80'(o_valid), 80'd0);

`ifdef RELU_SAT_CNT_EN
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
        check("t6_clr0", 80'(o_sat_cnt), 80'd0);
        for (int n = 0; n < 3; n++)
            run_beat("t6_t1", 80'h8000_012C_0064_0000_FFFB, 2'd0, 4'd0, 8'd0,
                     40'h00_FF_64_00_00, 5'b01000);
        check("t6_cnt3", 80'(o_sat_cnt), 80'd3);
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
        check("t6_clr", 80'(o_sat_cnt), 80'd0);
        // 13106 beats of five saturated lanes each: 65530.
        i_mode       = 2'd0;
        i_shift      = 4'd0;
        i_ready      = 1'b1;
        i_bound_data = 80'h012C_012C_012C_012C_012C;
        i_valid      = 1'b1;
        for (int n = 0; n < 13106; n++) tick();
        i_valid = 1'b0;
        repeat (3) tick();
        check("t6_near", 80'(o_sat_cnt), 80'd65530);
        run_beat("t6_top", 80'h012C_012C_012C_012C_012C, 2'd0, 4'd0, 8'd0,
                 40'hFF_FF_FF_FF_FF, 5'b11111);
        check("t6_max", 80'(o_sat_cnt), 80'hFFFF);
        run_beat("t6_over", 80'h012C_012C_012C_012C_012C, 2'd0, 4'd0, 8'd0,
                 40'hFF_FF_FF_FF_FF, 5'b11111);
        check("t6_nowrap", 80'(o_sat_cnt), 80'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/relu_array_pipe.md
Name: relu_array_pipe

Overview:
Pipelined, parametrised activation array for the RELU_BOUND datapath, successor to the combinational per-column ReLU stage. It takes one beat of COLS signed bound-stage results per valid/ready handshake. Each lane gets a rounding requantisation shift, one of four activation modes and saturation to ACT_BW. Results go to the activation buffer with 2-cycle latency and full backpressure support.

Parameters:
COLS, 5, number of parallel lanes (>=1)
BO_BW, 16, signed input width per lane (>=ACT_BW+1)
ACT_BW, 8, output width per lane
SHIFT_BW, 4, width of requantisation shift amount

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  input beat valid
o_ready  out  1  input beat accepted when i_valid && o_ready
i_bound_data  in  BO_BW*COLS  lane i at [(i+1)*BO_BW-1 -: BO_BW], two's complement
i_mode  in  2  0=ReLU, 1=clipped ReLU, 2=leaky (slope 1/8), 3=signed pass
i_shift  in  SHIFT_BW  arithmetic right shift with round-half-up
i_clip_max  in  ACT_BW  unsigned clip ceiling for mode 1
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts output beat
o_act_data  out  ACT_BW*COLS  lane i at [(i+1)*ACT_BW-1 -: ACT_BW]
o_sat_flag  out  COLS  bit i set when lane i saturated in this beat

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_act_data=0, o_sat_flag=0, all stage valids 0, all pipeline registers 0. o_ready follows from the empty pipeline and reads 1 during and after reset.
- Two register stages, S1 and S2. S2 drives the outputs.
- Enable terms: en2 = !o_valid || i_ready; en1 = !s1_valid || en2; o_ready = en1. o_ready is combinational.
- S1: on en1, capture i_bound_data, i_mode, i_shift, i_clip_max and s1_valid<=i_valid&&o_ready. Configuration is sampled per beat, so a mode change between beats takes effect exactly on the next accepted beat.
- S2: on en2, compute from S1 and set o_valid<=s1_valid. When o_valid && !i_ready, o_act_data and o_sat_flag hold stable.
- Latency: accepted at edge N gives o_valid at edge N+2 if not stalled. Throughput is 1 beat/cycle. Maximum 2 beats in flight.
- Per-lane arithmetic, evaluated in BO_BW+1 bits:
  - r = x when shift=0, else (x + 2^(shift-1)) >>> shift.
  - Shift values >= BO_BW are treated as BO_BW-1.
- Mode functions applied to r:
  - mode 0: max(r,0), saturate to [0, 2^ACT_BW-1].
  - mode 1: min(max(r,0), i_clip_max). Clipping is not saturation and does not set the flag.
  - mode 2: r>=0 ? r : r>>>3 (floor). Saturate signed to [-2^(ACT_BW-1), 2^(ACT_BW-1)-1].
  - mode 3: r, saturated signed as in mode 2.
- o_sat_flag[i]=1 exactly when ACT_BW range saturation altered lane i. The flag is registered alongside its data.
- Negative zero and rounding: values that round toward zero from below become 0 in modes 0 and 1, e.g. -2>>>2 = -1, which maps to 0.
- Reset mid-operation: in-flight beats are discarded. No partial beat emerges after release.
- Simultaneous stall and input: if S2 is stalled and S1 is full, o_ready=0. If S2 is stalled and S1 is empty, one beat is accepted into S1.

Optional Feature:
RELU_SAT_CNT_EN
- With it: adds ports i_sat_clr (in, 1) and o_sat_cnt (out, 16).
- On each output handshake (o_valid && i_ready), o_sat_cnt increases by popcount(o_sat_flag). The counter saturates at 16'hFFFF and does not wrap.
- i_sat_clr=1 zeroes the counter synchronously and has priority over increment.
- The counter resets to 0 on i_rst.
- Without it: the ports are absent and no counter logic is synthesised.

Test Plan:
1. Defaults, mode0, shift0, i_ready=1. Lanes 0..4 = {-5,0,100,300,-32768}. Expected after 2 cycles: {0,0,100,255,0}, o_sat_flag=5'b01000.
2. Mode1, clip_max=6, shift=2. Lanes {25,23,-4,2,1000}. Expected: {6,6,0,1,6}, o_sat_flag=0.
3. Mode2, shift0. Lanes {-80,-7,50,200,-2000}. Expected bytes: {F6,FF,32,7F,80}, o_sat_flag=5'b11000.
4. Stream 6 beats with i_ready low for 3 cycles mid-stream.
   - o_ready drops once 2 beats are held.
   - Held output stays stable while stalled.
   - All 6 beats arrive in order with no loss or duplication.
5. Assert i_rst for 1 cycle while o_valid=1.
   - o_valid, o_act_data and o_sat_flag go to 0 immediately.
   - A beat accepted on the first edge after release appears 2 edges later.
6. With RELU_SAT_CNT_EN: run scenario 1 three times and expect o_sat_cnt=3. Pulse i_sat_clr and expect 0. Preload near 16'hFFFF and confirm it saturates rather than wraps.
